mem_arbiter: RTL and testbench

Two-port arbiter that shares a single `memory` instance between the fetch path (I-port, read-only) and the memory stage (D-port, read/write). It serialises each requester's burst into per-word beats on the shared memory port. It also handles `busy` back-pressure and returns read data tagged to the owning port. It sits between `fetch` / the XM pipeline registers and the unified memory, replacing separate IMEM/DMEM instances.

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) burst arbiter onto one memory port; first beat 1 cycle after request, read data 1 cycle after accept.
// mem_busy stalls the current beat in place; optional ARB_ROUND_ROBIN_EN replaces fixed D-over-I priority with round robin.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [1:0]        i_size,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_rw,
    input  logic [1:0]        d_size,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wready,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_rw,
    output logic              mem_enable,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_XFER = 1'b1;

    logic              r_state;
    logic              w_next_state;
    logic              r_owner_d;
    logic [ADDR_W-1:0] r_base;
    logic [4:0]        r_beats;
    logic [4:0]        r_cnt;
    logic              r_rw;
    logic              r_i_rvalid;
    logic              r_d_rvalid;
    logic              r_i_done;
    logic              r_d_done;

    logic              w_xfer;
    logic              w_accept;
    logic              w_last;
    logic              w_pick_d;
    logic [1:0]        w_size;
    logic [4:0]        w_beats;
    logic [ADDR_W-1:0] w_sum;

    assign w_xfer   = (r_state == S_XFER);
    assign w_accept = w_xfer & ~mem_busy;
    assign w_last   = w_accept & (r_cnt == 5'(r_beats - 5'd1));
    assign w_sum    = r_base + {{(ADDR_W-7){1'b0}}, r_cnt, 2'b00};

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_d;
    // On a tie, hand the memory to whichever port did not have it last.
    assign w_pick_d = d_req & (~i_req | ~r_last_d);

    always_ff @(posedge clock) begin
        if (reset)
            r_last_d <= 1'b1;
        else if (!w_xfer && (i_req || d_req))
            r_last_d <= w_pick_d;
    end
`else
    assign w_pick_d = d_req;
`endif

    assign w_size = w_pick_d ? d_size : i_size;

    always_comb begin
        w_beats = 5'd1;
        case (w_size)
            2'b00:   w_beats = 5'd1;
            2'b01:   w_beats = 5'd4;
            2'b10:   w_beats = 5'd8;
            default: w_beats = 5'd16;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_req || d_req) w_next_state = S_XFER;
            default: if (w_last)         w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        i_gnt       = w_xfer & ~r_owner_d;
        d_gnt       = w_xfer & r_owner_d;
        mem_enable  = w_xfer;
        mem_rw      = w_xfer ? r_rw : 1'b1;
        mem_address = w_xfer ? {w_sum[ADDR_W-1:2], 2'b00} : '0;
        mem_data_in = (w_xfer && r_owner_d) ? d_wdata : '0;
        d_wready    = w_accept & r_owner_d & ~r_rw;
        i_rvalid    = r_i_rvalid;
        d_rvalid    = r_d_rvalid;
        i_done      = r_i_done;
        d_done      = r_d_done;
        rdata       = (r_i_rvalid || r_d_rvalid) ? mem_data_out : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner_d  <= 1'b0;
            r_base     <= '0;
            r_beats    <= 5'd1;
            r_cnt      <= 5'd0;
            r_rw       <= 1'b1;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_done   <= 1'b0;
            r_d_done   <= 1'b0;
        end else begin
            r_i_rvalid <= w_accept & r_rw & ~r_owner_d;
            r_d_rvalid <= w_accept & r_rw & r_owner_d;
            r_i_done   <= w_last & ~r_owner_d;
            r_d_done   <= w_last & r_owner_d;
            if (!w_xfer && (i_req || d_req)) begin
                // Fetch is read-only, so its rw is forced high.
                r_owner_d <= w_pick_d;
                r_base    <= w_pick_d ? d_addr : i_addr;
                r_rw      <= w_pick_d ? d_rw : 1'b1;
                r_beats   <= w_beats;
                r_cnt     <= 5'd0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_rw, mem_busy;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [1:0]  i_size, d_size;
    logic        i_gnt, i_rvalid, i_done, d_wready, d_gnt, d_rvalid, d_done;
    logic [31:0] rdata, mem_address, mem_data_in, mem_data_out;
    logic        mem_rw, mem_enable;

    localparam logic [31:0] K = 32'h5A5A_0000;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rv;
    logic [31:0] exp_a;
    logic        exp_d1, exp_d2;

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_size(i_size),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_rw(d_rw), .d_size(d_size),
        .d_wdata(d_wdata), .d_wready(d_wready), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_done(d_done), .rdata(rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_rw(mem_rw), .mem_enable(mem_enable),
        .mem_busy(mem_busy), .mem_data_out(mem_data_out)
    );

    // Memory returns a data word derived from the accepted read address.
    always @(posedge clock)
        if (mem_enable && !mem_busy && mem_rw)
            mem_data_out <= mem_address ^ K;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        mem_data_out = 32'h0;
        reset = 1'b1; i_req = 0; d_req = 0; d_rw = 1; mem_busy = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; i_size = 0; d_size = 0;
        step(); step();
        settle();
        chk("rst_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
        chk("rst_en", {31'd0, mem_enable}, 32'd0);
        chk("rst_rw", {31'd0, mem_rw}, 32'd1);
        chk("rst_addr", mem_address, 32'd0);
        chk("rst_flags", {27'd0, i_rvalid, d_rvalid, i_done, d_done, d_wready}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        step();

        // I read, 4 beats
        i_req = 1; i_addr = 32'h8002_0000; i_size = 2'b01;
        settle();
        chk("t1_idle_en", {31'd0, mem_enable}, 32'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) i_req = 0;
            settle();
            chk($sformatf("t1_gnt%0d", k), {31'd0, i_gnt}, (k < 4) ? 32'd1 : 32'd0);
            if (k < 4) chk($sformatf("t1_addr%0d", k), mem_address, 32'h8002_0000 + 32'(4 * k));
            chk($sformatf("t1_rv%0d", k), {31'd0, i_rvalid}, (k > 0) ? 32'd1 : 32'd0);
            if (k > 0) chk($sformatf("t1_rd%0d", k), rdata, (32'h8002_0000 + 32'(4 * (k - 1))) ^ K);
            chk($sformatf("t1_done%0d", k), {31'd0, i_done}, (k == 4) ? 32'd1 : 32'd0);
            step();
        end

        // D write, single beat, two busy cycles
        d_req = 1; d_addr = 32'h8002_0013; d_rw = 0; d_size = 2'b00;
        d_wdata = 32'hDEAD_BEEF; mem_busy = 1;
        step();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) mem_busy = 0;
            settle();
            chk($sformatf("t2_gnt%0d", k), {31'd0, d_gnt}, 32'd1);
            chk($sformatf("t2_addr%0d", k), mem_address, 32'h8002_0010);
            chk($sformatf("t2_rw%0d", k), {31'd0, mem_rw}, 32'd0);
            chk($sformatf("t2_wd%0d", k), mem_data_in, 32'hDEAD_BEEF);
            chk($sformatf("t2_wrdy%0d", k), {31'd0, d_wready}, (k == 2) ? 32'd1 : 32'd0);
            step();
        end
        d_req = 0;
        settle();
        chk("t2_done", {31'd0, d_done}, 32'd1);
        chk("t2_gnt_drop", {31'd0, d_gnt}, 32'd0);
        chk("t2_wrdy_off", {31'd0, d_wready}, 32'd0);
        step();

        // Two ties in a row
`ifdef ARB_ROUND_ROBIN_EN
        exp_d1 = 1'b0; exp_d2 = 1'b1;
`else
        exp_d1 = 1'b1; exp_d2 = 1'b1;
`endif
        i_req = 1; d_req = 1; d_rw = 1; i_size = 2'b00; d_size = 2'b00;
        i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
        step();
        settle();
        chk("t3_tie1", {30'd0, i_gnt, d_gnt}, {30'd0, ~exp_d1, exp_d1});
        step();
        settle();
        chk("t3_done1", {30'd0, i_done, d_done}, {30'd0, ~exp_d1, exp_d1});
        step();
        settle();
        chk("t3_tie2", {30'd0, i_gnt, d_gnt}, {30'd0, ~exp_d2, exp_d2});
        step();
        i_req = 0; d_req = 0;
        settle();
        chk("t3_done2", {30'd0, i_done, d_done}, {30'd0, ~exp_d2, exp_d2});
        step();
        if (i_gnt || d_gnt) begin
            // An I burst left pending by the ties must drain before the next test.
            step();
        end

        // D read, 16 beats, address wrap
        d_req = 1; d_rw = 1; d_size = 2'b11; d_addr = 32'hFFFF_FFF8;
        n_rv = 0;
        step();
        for (int k = 0; k < 17; k++) begin
            if (k == 16) d_req = 0;
            settle();
            exp_a = 32'hFFFF_FFF8 + 32'(4 * k);
            if (k == 2) chk("t4_wrap", mem_address, 32'h0000_0000);
            if (k < 16) chk($sformatf("t4_addr%0d", k), mem_address, exp_a);
            if (d_rvalid) begin
                n_rv++;
                chk($sformatf("t4_rd%0d", k), rdata, (exp_a - 32'd4) ^ K);
            end
            chk($sformatf("t4_done%0d", k), {31'd0, d_done}, (k == 16) ? 32'd1 : 32'd0);
            step();
        end
        chk("t4_nrv", 32'(n_rv), 32'd16);

        // Reset during beat 3 of an 8-beat I burst
        i_req = 1; i_addr = 32'h0000_1000; i_size = 2'b10;
        step();
        step();
        step();
        settle();
        chk("t5_beat3", mem_address, 32'h0000_1008);
        reset = 1;
        step();
        reset = 0; i_req = 0;
        settle();
        chk("t5_outs", {26'd0, i_gnt, d_gnt, i_rvalid, i_done, mem_enable, d_wready}, 32'd0);
        chk("t5_addr", mem_address, 32'd0);
        chk("t5_rdata", rdata, 32'd0);
        chk("t5_rw", {31'd0, mem_rw}, 32'd1);
        n_rv = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (i_rvalid || i_done || i_gnt) n_rv++;
        end
        chk("t5_quiet", 32'(n_rv), 32'd0);
        d_req = 1; d_rw = 1; d_size = 2'b00; d_addr = 32'h0000_0040;
        step();
        settle();
        chk("t5_dgnt", {31'd0, d_gnt}, 32'd1);
        chk("t5_daddr", mem_address, 32'h0000_0040);
        step();
        d_req = 0;
        settle();
        chk("t5_ddone", {30'd0, d_done, d_rvalid}, 32'd3);
        chk("t5_drd", rdata, 32'h0000_0040 ^ K);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
